noc_handshake_monitor: RTL and testbench

//  Passive protocol monitor for one valid/ready NoC channel (flit or credit link).

---
 rtl/noc_handshake_monitor.sv | 125 ++++++++++++
 tb/tb_noc_handshake_monitor.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/noc_handshake_monitor.sv
// Passive valid/ready protocol monitor: flags payload instability, valid withdrawal and handshake hang.
// Violation pulses are registered one cycle after the offending edge; sticky flags and a saturating count are kept for debug.
module noc_handshake_monitor #(
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  valid_i,
    input  logic                  ready_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  viol_stable_o,
    output logic                  viol_drop_o,
    output logic                  viol_timeout_o,
    output logic                  viol_any_o,
    output logic [2:0]            sticky_o,
    output logic [CNT_WIDTH-1:0]  viol_cnt_o
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $fatal(1, "noc_handshake_monitor: TIMEOUT_CYCLES must be >= 2");
    end

    localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HUNG = 2'd2
    } state_t;

    state_t                state;
    logic [WCW-1:0]        wait_cnt;
    logic [DATA_WIDTH-1:0] cap_data;

    logic                  det_stable;
    logic                  det_drop;
    logic                  det_timeout;
    logic [WCW-1:0]        wait_inc;
    logic [1:0]            viol_num;
    logic [CNT_WIDTH-1:0]  cnt_base;
    logic [CNT_WIDTH:0]    cnt_sum;
    logic [CNT_WIDTH-1:0]  cnt_nxt;

    // Violation detection for the current edge; wait_cnt never exceeds
    // WAIT_LIMIT-1 while in WAIT, so the increment cannot overflow.
    always_comb begin
        det_stable  = 1'b0;
        det_drop    = 1'b0;
        det_timeout = 1'b0;
        wait_inc    = wait_cnt + WCW'(1);
        if (state != IDLE) begin
            if (!valid_i) begin
                det_drop = 1'b1;
            end else begin
                det_stable = (data_i != cap_data);
                if (state == WAIT && !ready_i && wait_inc == WAIT_LIMIT) begin
                    det_timeout = 1'b1;
                end
            end
        end
    end

    // A clear on the same edge as a violation keeps only that edge's count.
    always_comb begin
        viol_num = {1'b0, det_stable} + {1'b0, det_drop} + {1'b0, det_timeout};
        cnt_base = clear_i ? '0 : viol_cnt_o;
        cnt_sum  = {1'b0, cnt_base} + (CNT_WIDTH+1)'(viol_num);
        cnt_nxt  = cnt_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : cnt_sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            cap_data       <= '0;
            viol_stable_o  <= 1'b0;
            viol_drop_o    <= 1'b0;
            viol_timeout_o <= 1'b0;
            viol_any_o     <= 1'b0;
            sticky_o       <= 3'b000;
            viol_cnt_o     <= '0;
        end else begin
            viol_stable_o  <= det_stable;
            viol_drop_o    <= det_drop;
            viol_timeout_o <= det_timeout;
            viol_any_o     <= det_stable | det_drop | det_timeout;
            sticky_o       <= (clear_i ? 3'b000 : sticky_o) | {det_timeout, det_drop, det_stable};
            viol_cnt_o     <= cnt_nxt;

            case (state)
                IDLE: begin
                    if (valid_i && !ready_i) begin
                        cap_data <= data_i;
                        wait_cnt <= WCW'(1);
                        state    <= WAIT;
                    end
                end
                WAIT, HUNG: begin
                    if (!valid_i || ready_i) begin
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        // Recapture so each distinct payload change flags once.
                        cap_data <= data_i;
                        if (state == WAIT) begin
                            wait_cnt <= wait_inc;
                            if (det_timeout) begin
                                state <= HUNG;
                            end
                        end
                    end
                end
                default: begin
                    wait_cnt <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_handshake_monitor.sv
// Randomized and directed bench for noc_handshake_monitor against a transaction-level reference model.
module tb_noc_handshake_monitor;

    localparam int DW = 8;
    localparam int TO = 4;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear_i = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          viol_stable_o, viol_drop_o, viol_timeout_o, viol_any_o;
    logic [2:0]    sticky_o;
    logic [CW-1:0] viol_cnt_o;

    int checks = 0;
    int errors = 0;

    noc_handshake_monitor #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .clear_i(clear_i),
        .valid_i(valid_i), .ready_i(ready_i), .data_i(data_i),
        .viol_stable_o(viol_stable_o), .viol_drop_o(viol_drop_o),
        .viol_timeout_o(viol_timeout_o), .viol_any_o(viol_any_o),
        .sticky_o(sticky_o), .viol_cnt_o(viol_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference model: an outstanding beat, how many edges it has been
    // waiting, whether its hang was already reported, and the last payload seen.
    bit            m_pend;
    int            m_age;
    bit            m_reported;
    logic [DW-1:0] m_last;
    logic [2:0]    e_pulse;
    logic [2:0]    e_sticky;
    int            e_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_age = 0; m_reported = 0; m_last = '0;
        e_pulse = 3'b000; e_sticky = 3'b000; e_cnt = 0;
    endtask

    task automatic model_edge(input bit v, input bit r, input logic [DW-1:0] d, input bit clr);
        bit st, dr, to;
        st = 0; dr = 0; to = 0;
        if (!m_pend) begin
            if (v && !r) begin
                m_pend = 1; m_age = 1; m_reported = 0; m_last = d;
            end
        end else if (!v) begin
            dr = 1; m_pend = 0;
        end else begin
            st = (d != m_last);
            m_last = d;
            if (r) begin
                m_pend = 0;
            end else begin
                m_age++;
                if (m_age == TO && !m_reported) begin
                    to = 1; m_reported = 1;
                end
            end
        end
        e_pulse  = {to, dr, st};
        e_cnt    = (clr ? 0 : e_cnt) + int'(st) + int'(dr) + int'(to);
        if (e_cnt > CNT_MAX) e_cnt = CNT_MAX;
        e_sticky = (clr ? 3'b000 : e_sticky) | e_pulse;
    endtask

    task automatic check_outputs();
        chk("pulses", {29'd0, viol_timeout_o, viol_drop_o, viol_stable_o}, {29'd0, e_pulse});
        chk("any", {31'd0, viol_any_o}, {31'd0, |e_pulse});
        chk("sticky", {29'd0, sticky_o}, {29'd0, e_sticky});
        chk("cnt", {28'd0, viol_cnt_o}, e_cnt);
    endtask

    task automatic step(input bit v, input bit r, input logic [DW-1:0] d, input bit clr);
        valid_i = v; ready_i = r; data_i = d; clear_i = clr;
        @(posedge clk);
        model_edge(v, r, d, clr);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_any", {31'd0, viol_any_o}, 32'd0);
        chk("rst_sticky", {29'd0, sticky_o}, 32'd0);
        chk("rst_cnt", {28'd0, viol_cnt_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int to_pulses;

    initial begin
        model_reset();
        #2;
        do_reset();

        // Legal transfer with a two-edge stall
        step(1, 0, 8'hA5, 0); step(1, 0, 8'hA5, 0); step(1, 1, 8'hA5, 0); step(0, 0, 8'h00, 0);
        chk("legal_sticky", {29'd0, sticky_o}, 32'd0);
        chk("legal_cnt", {28'd0, viol_cnt_o}, 32'd0);

        // Instability
        step(1, 0, 8'h11, 0); step(1, 0, 8'h22, 0);
        chk("instab_pulse", {31'd0, viol_stable_o}, 32'd1);
        chk("instab_sticky", {29'd0, sticky_o}, 32'd1);
        chk("instab_cnt", {28'd0, viol_cnt_o}, 32'd1);
        step(1, 1, 8'h22, 0);
        chk("instab_once", {31'd0, viol_stable_o}, 32'd0);

        // Drop
        step(0, 0, 8'h00, 1);
        step(1, 0, 8'h33, 0); step(0, 0, 8'h33, 0);
        chk("drop_pulse", {31'd0, viol_drop_o}, 32'd1);
        chk("drop_sticky1", {31'd0, sticky_o[1]}, 32'd1);

        // Hang: ten pending edges, a single timeout pulse, then quiet acceptance
        to_pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 8'h44, 0);
            if (i == 3) chk("hang_edge4", {31'd0, viol_timeout_o}, 32'd1);
            to_pulses += int'(viol_timeout_o);
        end
        chk("hang_single", to_pulses, 1);
        step(1, 1, 8'h44, 0);
        chk("hang_release", {31'd0, viol_any_o}, 32'd0);

        // Coincident stable + timeout
        step(0, 0, 8'h00, 1);
        step(1, 0, 8'h07, 0); step(1, 0, 8'h07, 0); step(1, 0, 8'h07, 0); step(1, 0, 8'h08, 0);
        chk("coin_both", {30'd0, viol_timeout_o, viol_stable_o}, 32'd3);
        chk("coin_cnt", {28'd0, viol_cnt_o}, 32'd2);
        step(1, 1, 8'h08, 0);

        // Saturation, then clear coincident with a drop
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 8'h01, 0); step(0, 0, 8'h01, 0);
        end
        chk("sat_cnt", {28'd0, viol_cnt_o}, CNT_MAX);
        step(1, 0, 8'h01, 0); step(0, 0, 8'h01, 1);
        chk("clr_cnt", {28'd0, viol_cnt_o}, 32'd1);
        chk("clr_sticky", {29'd0, sticky_o}, 32'd2);

        // Reset in the middle of a pending beat
        step(1, 0, 8'h03, 0); step(1, 0, 8'h03, 0);
        do_reset();
        step(0, 0, 8'h00, 0);
        chk("post_rst_no_drop", {31'd0, viol_drop_o}, 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit v, r, c;
            logic [DW-1:0] d;
            v = ($urandom_range(7) != 0);
            r = ($urandom_range(3) == 0);
            c = ($urandom_range(63) == 0);
            d = ($urandom_range(3) == 0) ? DW'($urandom_range(3)) : m_last;
            step(v, r, d, c);
            if ($urandom_range(499) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
